mem_line_arbiter: RTL and testbench

- Parametrised N-channel arbiter that lets several line caches (I-cache, D-cache, future L1 instances) share one slow line-memory port.
- Generalises the current one-memory-per-cache topology to a single memory.
- Sits between the cache memory-side interfaces and the top-level mem_* pins.
- Each channel sees the same read/write/addr/wdata/rdata/ready protocol it would see from a private slow memory.

---
 rtl/mem_line_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_line_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter
// Lets NUM_CH line caches share one slow line-memory port. Each channel sees
// the same read/write/addr/wdata/rdata/ready handshake it would get from a
// private memory. One access is in flight at a time: IDLE -> BUSY -> RESP.
// Arbitration is round-robin by default. Define MEM_ARB_FIXED_PRIO_EN for
// fixed priority instead (lowest channel index always wins).
module mem_line_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic [NUM_CH-1:0]        grant_oh,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic [LINE_W-1:0]        mem_rdata,
    input  logic                     mem_ready
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e              state_q,     state_d;
    logic [NUM_CH-1:0]   grant_q,     grant_d;
    logic [NUM_CH-1:0]   ready_q,     ready_d;
    logic                mem_read_q,  mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [LINE_W-1:0]   wdata_q,     wdata_d;
    logic [LINE_W-1:0]   rdata_q,     rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
    // Index of the most recent grantee; the search starts just after it.
    logic [IDX_W-1:0]    ptr_q,       ptr_d;
`endif

    logic [NUM_CH-1:0]   req;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    cand;

    // Pick the winning channel among all current requesters.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path can leave it unassigned and infer a latch.
        req       = ch_read | ch_write;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            cand = IDX_W'(k);
`else
            cand = IDX_W'((int'(ptr_q) + 1 + k) % NUM_CH);
`endif
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic of the IDLE/BUSY/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ready_d     = '0;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = BUSY;
                    grant_d     = NUM_CH'(1) << win_idx;
                    addr_d      = ch_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                    wdata_d     = ch_wdata[int'(win_idx)*LINE_W +: LINE_W];
                    // A winner asserting both read and write is treated as a write.
                    mem_write_d = ch_write[win_idx];
                    mem_read_d  = !ch_write[win_idx];
`ifndef MEM_ARB_FIXED_PRIO_EN
                    ptr_d       = win_idx;
`endif
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    if (mem_read_q) begin
                        rdata_d = mem_rdata;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    ready_d     = grant_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                // ch_ready is high this cycle; release the grant and go idle.
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            // NOTE: the address/data registers are cleared too because they
            // drive output pins directly and must read 0 after reset.
            state_q     <= IDLE;
            grant_q     <= '0;
            ready_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_q       <= IDX_W'(NUM_CH - 1);
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ready_q     <= ready_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign ch_rdata  = rdata_q;
    assign ch_ready  = ready_q;
    assign grant_oh  = grant_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter
// Directed stimulus against a 4-channel mem_line_arbiter. A transaction-level
// model predicts the outputs and is compared every cycle; literal expectations
// pin latency, data values and grant order. Honours MEM_ARB_FIXED_PRIO_EN.
module tb_mem_line_arbiter;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam int EXP_SIM  [3] = '{0, 0, 1};
    localparam int EXP_FAIR [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
    localparam int EXP_SIM  [3] = '{0, 1, 0};
    localparam int EXP_FAIR [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

    logic                     clk;
    logic                     rst_n;
    logic [NUM_CH-1:0]        ch_read;
    logic [NUM_CH-1:0]        ch_write;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*LINE_W-1:0] ch_wdata;
    logic [LINE_W-1:0]        ch_rdata;
    logic [NUM_CH-1:0]        ch_ready;
    logic [NUM_CH-1:0]        grant_oh;
    logic                     mem_read;
    logic                     mem_write;
    logic [ADDR_W-1:0]        mem_addr;
    logic [LINE_W-1:0]        mem_wdata;
    logic [LINE_W-1:0]        mem_rdata;
    logic                     mem_ready;

    mem_line_arbiter #(
        .NUM_CH(NUM_CH),
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_read  (ch_read),
        .ch_write (ch_write),
        .ch_addr  (ch_addr),
        .ch_wdata (ch_wdata),
        .ch_rdata (ch_rdata),
        .ch_ready (ch_ready),
        .grant_oh (grant_oh),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- requesters ----------------
    int                req_left  [NUM_CH];
    bit                rd_en     [NUM_CH];
    bit                wr_en     [NUM_CH];
    logic [ADDR_W-1:0] cfg_addr  [NUM_CH];
    logic [LINE_W-1:0] cfg_wdata [NUM_CH];

    // Each channel holds its request while transactions remain; one is
    // consumed per ch_ready pulse seen.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_ready[i] === 1'b1 && req_left[i] > 0) req_left[i]--;
            ch_read[i]  = (req_left[i] > 0) && rd_en[i];
            ch_write[i] = (req_left[i] > 0) && wr_en[i];
            ch_addr[i*ADDR_W +: ADDR_W]  = cfg_addr[i];
            ch_wdata[i*LINE_W +: LINE_W] = cfg_wdata[i];
        end
    end

    // ---------------- memory responder ----------------
    int                mem_lat = 5;
    int                wait_cnt = 0;
    logic              resp_ready = 1'b0;
    logic              stray_ready = 1'b0;
    logic [LINE_W-1:0] rdata_next = '0;
    logic [LINE_W-1:0] mem_rdata_r = '0;

    assign mem_ready = resp_ready | stray_ready;
    assign mem_rdata = mem_rdata_r;

    // Raise mem_ready after mem_lat cycles of strobe; rdata is only valid
    // during the ready cycle, garbage otherwise.
    always @(negedge clk) begin
        if (resp_ready) begin
            resp_ready  = 1'b0;
            mem_rdata_r = {4{32'hBAD0BAD0}};
            wait_cnt    = 0;
        end else if (mem_read === 1'b1 || mem_write === 1'b1) begin
            wait_cnt++;
            if (wait_cnt >= mem_lat) begin
                resp_ready  = 1'b1;
                mem_rdata_r = rdata_next;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // ---------------- transaction-level model ----------------
    bit                m_valid = 1'b0;
    bit                m_busy  = 1'b0;
    bit                m_done  = 1'b0;
    int                m_ch    = 0;
    bit                m_wr    = 1'b0;
    int                m_last  = NUM_CH - 1;
    int                m_win;
    int                m_cand;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [LINE_W-1:0] m_wdata = '0;
    logic [LINE_W-1:0] m_rdata = '0;

    // One owner at a time; owner is served, acknowledged, then a new owner is chosen.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_rdata = '0;
            m_last  = NUM_CH - 1;
        end else if (m_done) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (m_busy) begin
            if (mem_ready) begin
                m_done = 1'b1;
                if (!m_wr) m_rdata = mem_rdata;
            end
        end else begin
            m_win = -1;
            for (int k = 0; k < NUM_CH; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                m_cand = k;
`else
                m_cand = (m_last + 1 + k) % NUM_CH;
`endif
                if (m_win < 0 && (ch_read[m_cand] || ch_write[m_cand])) m_win = m_cand;
            end
            if (m_win >= 0) begin
                m_busy  = 1'b1;
                m_ch    = m_win;
                m_wr    = ch_write[m_win];
                m_addr  = ch_addr[m_win*ADDR_W +: ADDR_W];
                m_wdata = ch_wdata[m_win*LINE_W +: LINE_W];
                m_last  = m_win;
            end
        end
    end

    // ---------------- compare + monitor ----------------
    int                grant_log [$];
    int                ready_cnt [NUM_CH];
    logic [NUM_CH-1:0] prev_grant = '0;

    // Check DUT outputs against the model each cycle; log grants and ready pulses.
    always @(negedge clk) begin
        if (m_valid) begin
            check("grant_oh",  grant_oh,  m_busy ? (NUM_CH'(1) << m_ch) : NUM_CH'(0));
            check("ch_ready",  ch_ready,  m_done ? (NUM_CH'(1) << m_ch) : NUM_CH'(0));
            check("mem_read",  mem_read,  m_busy && !m_done && !m_wr);
            check("mem_write", mem_write, m_busy && !m_done && m_wr);
            check("ch_rdata",  ch_rdata,  m_rdata);
            if (m_busy && !m_done) begin
                check("mem_addr",  mem_addr,  m_addr);
                check("mem_wdata", mem_wdata, m_wdata);
            end
            if (grant_oh != '0 && prev_grant == '0) begin
                for (int i = 0; i < NUM_CH; i++) if (grant_oh[i]) grant_log.push_back(i);
            end
            for (int i = 0; i < NUM_CH; i++) if (ch_ready[i] === 1'b1) ready_cnt[i]++;
            prev_grant = grant_oh;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int ch, input bit rd, input bit wr,
                           input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata,
                           input int n);
        rd_en[ch]     = rd;
        wr_en[ch]     = wr;
        cfg_addr[ch]  = addr;
        cfg_wdata[ch] = wdata;
        req_left[ch]  = n;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        for (int i = 0; i < NUM_CH; i++) ready_cnt[i] = 0;
    endtask

    // Wait (bounded) for a ch_ready pulse; returns cycles waited.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (ch_ready == '0 && cycles < 40);
        if (ch_ready == '0) check("ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic check_log(input string name, input int idx, input int exp);
        check(name, (idx < grant_log.size()) ? grant_log[idx] : -1, exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  cyc;
        bit  any_strobe;
        logic [LINE_W-1:0] w0;

        rst_n = 1'b0;
        for (int i = 0; i < NUM_CH; i++) set_req(i, 1'b0, 1'b0, '0, '0, 0);
        ch_read  = '0;
        ch_write = '0;
        ch_addr  = '0;
        ch_wdata = '0;
        w0 = 128'h11112222_33334444_55556666_77778888;

        // Reset: three cycles low, everything 0.
        repeat (3) tick();
        check("rst_grant",     grant_oh,  4'b0000);
        check("rst_ready",     ch_ready,  4'b0000);
        check("rst_mem_read",  mem_read,  1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_addr",  mem_addr,  28'h0);
        check("rst_mem_wdata", mem_wdata, 128'h0);
        check("rst_ch_rdata",  ch_rdata,  128'h0);
        rst_n = 1'b1;

        // Idle with no requests; a stray mem_ready must be ignored.
        any_strobe = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stray_ready = (i == 4 || i == 5);
            tick();
            if (mem_read || mem_write || ch_ready != '0) any_strobe = 1'b1;
        end
        stray_ready = 1'b0;
        check("idle_no_activity", any_strobe, 1'b0);
        check("idle_grant",       grant_oh,   4'b0000);
        check("idle_rdata",       ch_rdata,   128'h0);

        // Single read on channel 1, memory answers after 5 cycles.
        clear_logs();
        mem_lat    = 5;
        rdata_next = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        set_req(1, 1'b1, 1'b0, 28'h0000123, '0, 1);
        tick();
        check("rd_grant",    grant_oh,  4'b0010);
        check("rd_mem_read", mem_read,  1'b1);
        check("rd_mem_addr", mem_addr,  28'h0000123);
        wait_ready(cyc);
        check("rd_latency",  cyc,       5);
        check("rd_ch_ready", ch_ready,  4'b0010);
        check("rd_ch_rdata", ch_rdata,  128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
        tick();
        check("rd_pulse_one", ch_ready, 4'b0000);
        repeat (3) tick();

        // Simultaneous: ch0 write (two back-to-back transactions) and ch1 read.
        clear_logs();
        mem_lat    = 2;
        rdata_next = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;
        set_req(0, 1'b0, 1'b1, 28'h0000A00, w0, 2);
        set_req(1, 1'b1, 1'b0, 28'h0000B00, '0, 1);
        tick();
        check("sim_grant",     grant_oh,  4'b0001);
        check("sim_mem_write", mem_write, 1'b1);
        check("sim_mem_read",  mem_read,  1'b0);
        check("sim_mem_wdata", mem_wdata, w0);
        wait_ready(cyc);
        check("sim_ready0",    ch_ready,  4'b0001);
        check("sim_wr_keeps_rdata", ch_rdata, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
        repeat (30) tick();
        check("sim_log_size", grant_log.size(), 3);
        for (int i = 0; i < 3; i++) check_log("sim_order", i, EXP_SIM[i]);

        // Channel 2 drops its read while BUSY: the access still completes once.
        clear_logs();
        mem_lat = 6;
        set_req(2, 1'b1, 1'b0, 28'h0000C20, '0, 1);
        tick();
        check("drop_grant", grant_oh, 4'b0100);
        req_left[2] = 0;
        repeat (20) tick();
        check("drop_one_ready", ready_cnt[2], 1);
        check("drop_log_size",  grant_log.size(), 1);

        // Read and write both set on the winner: write wins.
        clear_logs();
        mem_lat = 1;
        set_req(0, 1'b1, 1'b1, 28'h0000D00, w0, 1);
        tick();
        check("rw_mem_write", mem_write, 1'b1);
        check("rw_mem_read",  mem_read,  1'b0);
        repeat (8) tick();

        // Reset in the middle of a channel-0 read.
        clear_logs();
        mem_lat = 10;
        set_req(0, 1'b1, 1'b0, 28'h0000E00, '0, 1);
        tick();
        check("abort_grant", grant_oh, 4'b0001);
        repeat (2) tick();
        rst_n = 1'b0;
        set_req(1, 1'b1, 1'b0, 28'h0000F00, '0, 1);
        clear_logs();
        tick();
        check("abort_mem_read", mem_read, 1'b0);
        check("abort_grant0",   grant_oh, 4'b0000);
        tick();
        check("abort_no_ready", ready_cnt[0], 0);
        mem_lat = 2;
        rst_n   = 1'b1;
        repeat (30) tick();
        check("abort_log_size", grant_log.size(), 2);
        check_log("abort_first", 0, 0);
        check_log("abort_second", 1, 1);
        check("abort_ready0", ready_cnt[0], 1);

        // Fairness: fresh reset, all four channels request two lines each.
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        clear_logs();
        mem_lat = 1;
        set_req(0, 1'b1, 1'b0, 28'h0000100, '0, 2);
        set_req(1, 1'b0, 1'b1, 28'h0000200, w0, 2);
        set_req(2, 1'b1, 1'b0, 28'h0000300, '0, 2);
        set_req(3, 1'b1, 1'b1, 28'h0000400, ~w0, 2);
        repeat (50) tick();
        check("fair_log_size", grant_log.size(), 8);
        for (int i = 0; i < 8; i++) check_log("fair_order", i, EXP_FAIR[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound on simulation time.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
